hub75_frame_writer: RTL and testbench

- Loads images into the frame RAM that the HUB75 panel driver scans out; it is the writer side of that RAM.
- Accepts a raster-order RGB byte stream (host/UART/SPI bridge side) through a valid/ready handshake.
- Packs each pixel into the 48-bit dual-row word format the driver reads: upper row y in [47:24], lower row y+16 in [23:0], R/G/B per half MSB-first.
- Writes with byte enables into one of 12 image slots, addressed exactly as the driver addresses them.

---
 rtl/hub75_frame_writer.sv | 145 ++++++++++++++
 tb/tb_hub75_frame_writer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_frame_writer.sv
// Writer side of the HUB75 frame RAM: packs a raster RGB byte stream into dual-row 48-bit words.
// Optional HUB75_GAMMA_EN squares each channel ((x*x)>>8) on its way into the RAM.
module hub75_frame_writer #(
  parameter int pixel_depth  = 8,
  parameter int panel_width  = 64,
  parameter int panel_height = 32,
  parameter int addr_width   = 15,
  parameter int num_slots    = 12
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [pixel_depth-1:0]   in_data,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [3:0]               in_slot,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [addr_width-1:0]    wr_addr,
  output logic [6*pixel_depth-1:0] wr_data,
  output logic [5:0]               wr_be,
  output logic                     frame_done,
  output logic [3:0]               done_slot,
  output logic                     sof_err
);

  localparam int COL_W = $clog2(panel_width);
  localparam int ROW_W = $clog2(panel_height);
  localparam int HALF_W = 3*pixel_depth;
  localparam logic [3:0]       SLOT_LIM = 4'(num_slots);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(panel_width - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(panel_height - 1);
  localparam logic [ROW_W-1:0] ROW_HALF = ROW_W'(panel_height / 2);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                 state;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic [1:0]             byte_idx;
  logic [3:0]             slot_q;
  logic [pixel_depth-1:0] r_q, g_q;
  logic                   fin_p1;

  function automatic logic [pixel_depth-1:0] gamma(input logic [pixel_depth-1:0] x);
`ifdef HUB75_GAMMA_EN
    logic [2*pixel_depth-1:0] sq;
    sq = x * x;
    return sq[2*pixel_depth-1:pixel_depth];
`else
    return x;
`endif
  endfunction

  // Upper rows land in the high half, lower rows in the low half of the shared word.
  function automatic logic [6*pixel_depth-1:0] pack(input logic upper,
                                                    input logic [pixel_depth-1:0] r,
                                                    input logic [pixel_depth-1:0] g,
                                                    input logic [pixel_depth-1:0] b);
    logic [HALF_W-1:0] rgb;
    rgb = {gamma(r), gamma(g), gamma(b)};
    return upper ? {rgb, {HALF_W{1'b0}}} : {{HALF_W{1'b0}}, rgb};
  endfunction

  assign in_ready = 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      byte_idx   <= '0;
      slot_q     <= '0;
      r_q        <= '0;
      g_q        <= '0;
      fin_p1     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_be      <= '0;
      frame_done <= 1'b0;
      done_slot  <= '0;
      sof_err    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;

      // Stage p1 -> p2: the last write is out, report completion and fall back to IDLE.
      if (fin_p1) begin
        fin_p1     <= 1'b0;
        frame_done <= 1'b1;
        done_slot  <= slot_q;
        state      <= IDLE;
        row        <= '0;
        col        <= '0;
        byte_idx   <= '0;
      end

      if (in_valid && in_ready) begin
        if (in_sof) begin
          row <= '0;
          col <= '0;
          if (in_slot < SLOT_LIM) begin
            slot_q   <= in_slot;
            r_q      <= in_data;
            byte_idx <= 2'd1;
            state    <= RECV;
            sof_err  <= (state == RECV) && !fin_p1;
          end else begin
            byte_idx <= '0;
            state    <= IDLE;
            sof_err  <= 1'b1;
          end
        end else if (state == RECV && !fin_p1) begin
          // Stage p0 -> p1: B byte completes the pixel and registers the RAM write.
          case (byte_idx)
            2'd0: begin
              r_q      <= in_data;
              byte_idx <= 2'd1;
            end
            2'd1: begin
              g_q      <= in_data;
              byte_idx <= 2'd2;
            end
            default: begin
              byte_idx <= '0;
              wr_en    <= 1'b1;
              wr_addr  <= {slot_q, 1'b0, row[ROW_W-2:0], col};
              wr_data  <= pack(row < ROW_HALF, r_q, g_q, in_data);
              wr_be    <= (row < ROW_HALF) ? 6'b111000 : 6'b000111;
              if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) fin_p1 <= 1'b1;
                else                 row    <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hub75_frame_writer.sv
// Directed bench for hub75_frame_writer: full frames, gaps, bad slots, aborts and reset.
module tb_hub75_frame_writer;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [3:0]  in_slot = '0;
  logic        in_ready;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [47:0] wr_data;
  logic [5:0]  wr_be;
  logic        frame_done;
  logic [3:0]  done_slot;
  logic        sof_err;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int se_cnt = 0;
  logic [14:0] qa[$];
  logic [47:0] qd[$];
  logic [5:0]  qb[$];

  hub75_frame_writer dut (
    .clk_in(clk_in), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_slot(in_slot), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .frame_done(frame_done), .done_slot(done_slot), .sof_err(sof_err)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (wr_en) begin
      qa.push_back(wr_addr);
      qd.push_back(wr_data);
      qb.push_back(wr_be);
    end
    if (frame_done) fd_cnt++;
    if (sof_err) se_cnt++;
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] x);
`ifdef HUB75_GAMMA_EN
    logic [15:0] sq;
    sq = x * x;
    return sq[15:8];
`else
    return x;
`endif
  endfunction

  function automatic logic [68:0] model(input int p, input int slot);
    int row, col;
    logic [7:0] r, g, b;
    logic [14:0] a;
    logic [47:0] d;
    logic [5:0] be;
    row = p / 64;
    col = p % 64;
    r = 8'((p*3) % 256);
    g = 8'((p*3 + 1) % 256);
    b = 8'((p*3 + 2) % 256);
    a = 15'(slot*2048 + (row % 16)*64 + col);
    if (row < 16) begin
      d = {gm(r), gm(g), gm(b), 24'h0};
      be = 6'b111000;
    end else begin
      d = {24'h0, gm(r), gm(g), gm(b)};
      be = 6'b000111;
    end
    return {a, be, d};
  endfunction

  task automatic clear_mon();
    qa.delete();
    qd.delete();
    qb.delete();
    fd_cnt = 0;
    se_cnt = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic sof, input logic [3:0] sl, input int gapmax);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    in_slot  = sl;
    @(posedge clk_in);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (gapmax > 0) begin
      repeat ($urandom_range(0, gapmax)) @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_frame(input int slot, input int gapmax, input int npix);
    for (int p = 0; p < npix; p++)
      for (int k = 0; k < 3; k++)
        send(8'((p*3 + k) % 256), (p == 0 && k == 0), 4'(slot), gapmax);
  endtask

  task automatic verify(input string tag, input int base, input int slot, input int n);
    int e0;
    e0 = errors;
    if (qa.size() < base + n) begin
      check({tag, "_count"}, 72'(qa.size()), 72'(base + n));
    end else begin
      for (int i = 0; i < n; i++) begin
        check(tag, {3'b0, qa[base+i], qb[base+i], qd[base+i]}, {3'b0, model(i, slot)});
        if (errors != e0) break;
      end
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk_in);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;
    check("rst_ready", 72'(in_ready), 72'd1);
    check("rst_outs", {8'h0, wr_en, wr_addr, wr_be, frame_done, done_slot, sof_err},
          72'h0);
    check("rst_data", 72'(wr_data), 72'h0);

    // single pixel, latency of one cycle after B
    clear_mon();
    send(8'h12, 1'b1, 4'd0, 0);
    send(8'h34, 1'b0, 4'd0, 0);
    check("px_pre", 72'(wr_en), 72'd0);
    send(8'h56, 1'b0, 4'd0, 0);
    check("px_en", 72'(wr_en), 72'd1);
    check("px_addr", 72'(wr_addr), 72'd0);
`ifdef HUB75_GAMMA_EN
    check("px_data", 72'(wr_data), 72'h010A1C000000);
`else
    check("px_data", 72'(wr_data), 72'h123456000000);
`endif
    check("px_be", 72'(wr_be), 72'b111000);
    @(posedge clk_in); #1;
    check("px_en_off", 72'(wr_en), 72'd0);
    rst = 1'b1;
    @(posedge clk_in); #1;
    rst = 1'b0;

    // gap-free full frame to slot 3
    clear_mon();
    send_frame(3, 0, 2047);
    send(8'((2047*3) % 256), 1'b0, 4'd3, 0);
    send(8'((2047*3 + 1) % 256), 1'b0, 4'd3, 0);
    send(8'((2047*3 + 2) % 256), 1'b0, 4'd3, 0);
    check("last_wr", 72'(wr_en), 72'd1);
    check("done_early", 72'(frame_done), 72'd0);
    @(posedge clk_in); #1;
    check("done_pulse", 72'(frame_done), 72'd1);
    check("done_slot", 72'(done_slot), 72'd3);
    @(posedge clk_in); #1;
    check("done_off", 72'(frame_done), 72'd0);
    settle();
    check("f1_writes", 72'(qa.size()), 72'd2048);
    verify("f1_wr", 0, 3, 2048);
    if (qa.size() > 1093) begin
      check("f1_px17_5_addr", 72'(qa[1093]), 72'd6213);
      check("f1_px17_5_be", 72'(qb[1093]), 72'b000111);
    end else begin
      check("f1_px17_5_present", 72'(qa.size()), 72'd2048);
    end
    check("f1_done_cnt", 72'(fd_cnt), 72'd1);
    check("f1_err_cnt", 72'(se_cnt), 72'd0);

    // same frame with random gaps
    clear_mon();
    send_frame(3, 10, 2048);
    settle();
    check("gap_writes", 72'(qa.size()), 72'd2048);
    verify("gap_wr", 0, 3, 2048);
    check("gap_done_cnt", 72'(fd_cnt), 72'd1);
    check("gap_done_slot", 72'(done_slot), 72'd3);

    // rejected slot, then slot 11 aborted after 100 pixels and restarted
    clear_mon();
    send(8'hAA, 1'b1, 4'd12, 0);
    check("bad_slot_err", 72'(sof_err), 72'd1);
    send(8'hBB, 1'b0, 4'd0, 0);
    check("bad_slot_err_off", 72'(sof_err), 72'd0);
    send(8'hCC, 1'b0, 4'd0, 0);
    send(8'hDD, 1'b0, 4'd0, 0);
    settle();
    check("bad_slot_writes", 72'(qa.size()), 72'd0);
    check("bad_slot_err_cnt", 72'(se_cnt), 72'd1);
    send_frame(11, 0, 100);
    settle();
    check("abort_pre_err", 72'(se_cnt), 72'd1);
    send_frame(11, 0, 2048);
    settle();
    check("abort_err_cnt", 72'(se_cnt), 72'd2);
    check("abort_done_cnt", 72'(fd_cnt), 72'd1);
    check("abort_writes", 72'(qa.size()), 72'd2148);
    verify("abort_part", 0, 11, 100);
    verify("abort_full", 100, 11, 2048);
    if (qa.size() > 100) check("restart_addr", 72'(qa[100]), 72'd22528);
    check("slot11_done", 72'(done_slot), 72'd11);

    // reset mid-frame, then a clean frame
    clear_mon();
    send_frame(5, 0, 50);
    rst = 1'b1;
    @(posedge clk_in); #1;
    rst = 1'b0;
    check("rst_mid_outs", {8'h0, wr_en, wr_addr, wr_be, frame_done, done_slot, sof_err},
          72'h0);
    check("rst_mid_data", 72'(wr_data), 72'h0);
    check("rst_mid_writes", 72'(qa.size()), 72'd50);
    clear_mon();
    send_frame(5, 0, 2048);
    settle();
    check("rst_new_writes", 72'(qa.size()), 72'd2048);
    verify("rst_new_wr", 0, 5, 2048);
    check("rst_new_done", 72'(fd_cnt), 72'd1);
    check("rst_new_err", 72'(se_cnt), 72'd0);
    check("rst_new_slot", 72'(done_slot), 72'd5);

    // saturating-ish colour values through the channel path
    send(8'd255, 1'b1, 4'd2, 0);
    send(8'd128, 1'b0, 4'd2, 0);
    send(8'd16, 1'b0, 4'd2, 0);
    check("gm_addr", 72'(wr_addr), 72'd4096);
`ifdef HUB75_GAMMA_EN
    check("gm_data", 72'(wr_data), 72'hFE4001000000);
`else
    check("gm_data", 72'(wr_data), 72'hFF8010000000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
